// File: rtl/ship_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ship_ctrl_pkg
// Purpose  : Shared state type, default frame budgets and width helpers for
//            the ship lifecycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package ship_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SPAWN        = 3'd1,
        INVULN       = 3'd2,
        ALIVE        = 3'd3,
        EXPLODE      = 3'd4,
        RESPAWN_WAIT = 3'd5
    } ship_state_t;

    localparam int c_DEF_LIVES          = 3;
    localparam int c_DEF_INVULN_FRAMES  = 120;
    localparam int c_DEF_BLINK_FRAMES   = 8;
    localparam int c_DEF_EXPLODE_FRAMES = 32;
    localparam int c_DEF_EXPLODE_STEP   = 4;
    localparam int c_DEF_RESPAWN_FRAMES = 60;
    localparam int c_DEF_ANIM_DIV       = 6;

    // Frame counter must hold the largest per-state frame budget.
    function automatic int fcnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    function automatic int idx_width(input int frames, input int step);
        int n;
        n = $clog2(frames / step);
        return (n < 1) ? 1 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ship_lifecycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ship_lifecycle_ctrl_if
// Purpose  : Game-side request/status bundle of the ship lifecycle controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ship_lifecycle_ctrl_if #(
    parameter int LIVES_W = 2,
    parameter int IDX_W   = 3
) ();
    logic               frame_pulse;
    logic               start;
    logic               collision;
    logic               game_over;
    logic               ship_resetN;
    logic               draw_mask;
    logic               collision_en;
    logic               exploding;
    logic [IDX_W-1:0]   explode_idx;
    logic [LIVES_W-1:0] lives;
    logic               anim_pulse;

    modport master (
        output frame_pulse, start, collision,
        input  game_over, ship_resetN, draw_mask, collision_en,
               exploding, explode_idx, lives, anim_pulse
    );

    modport slave (
        input  frame_pulse, start, collision,
        output game_over, ship_resetN, draw_mask, collision_en,
               exploding, explode_idx, lives, anim_pulse
    );
endinterface
`default_nettype wire

// File: rtl/frame_divider.sv
`default_nettype none
// ============================================================================
// Module   : frame_divider
// Purpose  : Counts frame pulses and emits a registered one-cycle strobe on
//            the pulse that completes every DIV frames.
// Revision : 1.0 - initial release
// ============================================================================
module frame_divider #(
    parameter int DIV = 6
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_frame_pulse,
    output logic      o_strobe
);
    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (i_frame_pulse) begin
                if (r_cnt == c_CNT_W'(DIV - 1)) begin
                    r_cnt    <= '0;
                    r_strobe <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign o_strobe = r_strobe;
endmodule
`default_nettype wire

// File: rtl/ship_lifecycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ship_lifecycle_ctrl
// Purpose  : Frame-synchronous spawn/invuln/flight/explode/respawn sequencer
//            with life counting; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module ship_lifecycle_ctrl
    import ship_ctrl_pkg::*;
#(
    parameter int LIVES          = c_DEF_LIVES,
    parameter int INVULN_FRAMES  = c_DEF_INVULN_FRAMES,
    parameter int BLINK_FRAMES   = c_DEF_BLINK_FRAMES,
    parameter int EXPLODE_FRAMES = c_DEF_EXPLODE_FRAMES,
    parameter int EXPLODE_STEP   = c_DEF_EXPLODE_STEP,
    parameter int RESPAWN_FRAMES = c_DEF_RESPAWN_FRAMES,
    parameter int ANIM_DIV       = c_DEF_ANIM_DIV
) (
    input  wire logic            clk,
    input  wire logic            reset,
    ship_lifecycle_ctrl_if.slave bus
);
    localparam int c_FCNT_W    = fcnt_width(INVULN_FRAMES, EXPLODE_FRAMES, RESPAWN_FRAMES);
    localparam int c_IDX_W     = idx_width(EXPLODE_FRAMES, EXPLODE_STEP);
    localparam int c_LIVES_W   = $clog2(LIVES + 1);
    localparam int c_BLINK_BIT = $clog2(BLINK_FRAMES);

    ship_state_t          r_state, w_state_nxt;
    logic [c_FCNT_W-1:0]  r_fcnt, w_fcnt_nxt, w_limit;
    logic [c_LIVES_W-1:0] r_lives, w_lives_nxt;
    logic                 w_frame_done;

    logic                 r_game_over, r_ship_resetN, r_draw_mask, r_collision_en, r_exploding;
    logic                 w_game_over, w_ship_resetN, w_draw_mask, w_collision_en, w_exploding;
    logic [c_IDX_W-1:0]   r_explode_idx, w_explode_idx;
    logic                 w_anim_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_fcnt         <= '0;
            r_lives        <= '0;
            r_game_over    <= 1'b1;
            r_ship_resetN  <= 1'b0;
            r_draw_mask    <= 1'b0;
            r_collision_en <= 1'b0;
            r_exploding    <= 1'b0;
            r_explode_idx  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_fcnt         <= w_fcnt_nxt;
            r_lives        <= w_lives_nxt;
            r_game_over    <= w_game_over;
            r_ship_resetN  <= w_ship_resetN;
            r_draw_mask    <= w_draw_mask;
            r_collision_en <= w_collision_en;
            r_exploding    <= w_exploding;
            r_explode_idx  <= w_explode_idx;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_fcnt_nxt  = r_fcnt;

        case (r_state)
            INVULN:       w_limit = c_FCNT_W'(INVULN_FRAMES - 1);
            EXPLODE:      w_limit = c_FCNT_W'(EXPLODE_FRAMES - 1);
            RESPAWN_WAIT: w_limit = c_FCNT_W'(RESPAWN_FRAMES - 1);
            default:      w_limit = '0;
        endcase
        // The pulse that would make fcnt reach the budget ends the state.
        w_frame_done = bus.frame_pulse && (r_fcnt == w_limit);

        case (r_state)
            IDLE: if (bus.start) begin
                w_state_nxt = SPAWN;
                w_lives_nxt = c_LIVES_W'(LIVES);
            end
            SPAWN:  w_state_nxt = INVULN;
            INVULN: if (w_frame_done) w_state_nxt = ALIVE;
            ALIVE: if (bus.collision) begin
                w_state_nxt = EXPLODE;
                if (r_lives != '0) w_lives_nxt = r_lives - c_LIVES_W'(1);
            end
            EXPLODE:      if (w_frame_done) w_state_nxt = RESPAWN_WAIT;
            RESPAWN_WAIT: if (w_frame_done) w_state_nxt = (r_lives != '0) ? SPAWN : IDLE;
            default:      w_state_nxt = IDLE;
        endcase

        if (w_state_nxt != r_state) begin
            w_fcnt_nxt = '0;
        end else if (bus.frame_pulse) begin
            w_fcnt_nxt = r_fcnt + c_FCNT_W'(1);
        end

        // Outputs decoded from the upcoming state so the flops carry it.
        w_game_over    = (w_state_nxt == IDLE);
        w_ship_resetN  = !((w_state_nxt == IDLE) || (w_state_nxt == SPAWN));
        w_collision_en = (w_state_nxt == ALIVE);
        w_exploding    = (w_state_nxt == EXPLODE);
        w_explode_idx  = w_exploding ? c_IDX_W'(w_fcnt_nxt / c_FCNT_W'(EXPLODE_STEP)) : '0;
        case (w_state_nxt)
            INVULN:         w_draw_mask = ~w_fcnt_nxt[c_BLINK_BIT];
            ALIVE, EXPLODE: w_draw_mask = 1'b1;
            default:        w_draw_mask = 1'b0;
        endcase
    end

    frame_divider #(
        .DIV (ANIM_DIV)
    ) u_anim_div (
        .clk           (clk),
        .reset         (reset),
        .i_frame_pulse (bus.frame_pulse),
        .o_strobe      (w_anim_pulse)
    );

    assign bus.game_over    = r_game_over;
    assign bus.ship_resetN  = r_ship_resetN;
    assign bus.draw_mask    = r_draw_mask;
    assign bus.collision_en = r_collision_en;
    assign bus.exploding    = r_exploding;
    assign bus.explode_idx  = r_explode_idx;
    assign bus.lives        = r_lives;
    assign bus.anim_pulse   = w_anim_pulse;
endmodule
`default_nettype wire

// File: tb/tb_ship_lifecycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ship_lifecycle_ctrl
// Purpose  : Self-checking bench: vector table, corner sequences and random
//            stimulus against a frame-budget reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ship_lifecycle_ctrl;
    localparam int LIVES          = 3;
    localparam int INVULN_FRAMES  = 120;
    localparam int BLINK_FRAMES   = 8;
    localparam int EXPLODE_FRAMES = 32;
    localparam int EXPLODE_STEP   = 4;
    localparam int RESPAWN_FRAMES = 60;
    localparam int ANIM_DIV       = 6;
    localparam int LIVES_W        = 2;
    localparam int IDX_W          = 3;

    localparam int P_IDLE = 0, P_SPAWN = 1, P_INV = 2, P_ALIVE = 3, P_EXP = 4, P_RW = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ship_lifecycle_ctrl_if #(.LIVES_W(LIVES_W), .IDX_W(IDX_W)) bus ();

    ship_lifecycle_ctrl #(
        .LIVES(LIVES), .INVULN_FRAMES(INVULN_FRAMES), .BLINK_FRAMES(BLINK_FRAMES),
        .EXPLODE_FRAMES(EXPLODE_FRAMES), .EXPLODE_STEP(EXPLODE_STEP),
        .RESPAWN_FRAMES(RESPAWN_FRAMES), .ANIM_DIV(ANIM_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: phase plus remaining/elapsed frame budget.
    int m_phase, m_left, m_elapsed, m_lives, m_frames;
    bit m_anim;

    task automatic enter(input int ph, input int n);
        m_phase = ph; m_left = n; m_elapsed = 0;
    endtask

    task automatic model_reset();
        enter(P_IDLE, 0);
        m_lives = 0; m_frames = 0; m_anim = 1'b0;
    endtask

    task automatic model_step(input bit fp, input bit st, input bit col);
        m_anim = 1'b0;
        if (fp) begin
            m_frames++;
            m_anim = (m_frames % ANIM_DIV) == 0;
        end
        case (m_phase)
            P_IDLE:  if (st) begin m_lives = LIVES; enter(P_SPAWN, 0); end
            P_SPAWN: enter(P_INV, INVULN_FRAMES);
            P_ALIVE: if (col) begin
                if (m_lives > 0) m_lives--;
                enter(P_EXP, EXPLODE_FRAMES);
            end
            default: if (fp) begin
                m_left--; m_elapsed++;
                if (m_left == 0) begin
                    if (m_phase == P_INV)      enter(P_ALIVE, 0);
                    else if (m_phase == P_EXP) enter(P_RW, RESPAWN_FRAMES);
                    else                       enter((m_lives > 0) ? P_SPAWN : P_IDLE, 0);
                end
            end
        endcase
    endtask

    function automatic logic [10:0] model_outs();
        logic dm;
        logic [IDX_W-1:0] idx;
        dm  = (m_phase == P_ALIVE) || (m_phase == P_EXP) ||
              ((m_phase == P_INV) && (((m_elapsed / BLINK_FRAMES) % 2) == 0));
        idx = (m_phase == P_EXP) ? IDX_W'(m_elapsed / EXPLODE_STEP) : '0;
        return {m_phase == P_IDLE, !(m_phase == P_IDLE || m_phase == P_SPAWN), dm,
                m_phase == P_ALIVE, m_phase == P_EXP, idx, LIVES_W'(m_lives), m_anim};
    endfunction

    task automatic check_model(input string tag);
        logic [10:0] act, want, mask;
        act  = {bus.game_over, bus.ship_resetN, bus.draw_mask, bus.collision_en,
                bus.exploding, bus.explode_idx, bus.lives, bus.anim_pulse};
        want = model_outs();
        mask = 11'h7FF;
        if (m_phase == P_SPAWN) mask[8] = 1'b0;   // visibility during the spawn cycle is free
        total++;
        if ((act & mask) !== (want & mask)) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%03h want=%03h (go,rn,dm,ce,ex,idx,lives,anim)",
                     tag, cyc, act, want);
        end
    endtask

    task automatic expect_val(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
        end
    endtask

    task automatic cycle(input bit fp, input bit st, input bit col);
        bus.frame_pulse = fp; bus.start = st; bus.collision = col;
        @(posedge clk);
        model_step(fp, st, col);
        #1;
        cyc++;
        check_model("model");
    endtask

    task automatic apply_frames(input int n, input bit st, input bit col);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, st, col);
            cycle(1'b0, st, col);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.frame_pulse = 1'b0; bus.start = 1'b0; bus.collision = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        cyc++;
        check_model("reset");
        reset = 1'b0;
    endtask

    typedef struct {
        int frames;
        bit st, col;
        bit go, rn, dm, dmc, ce, ex;
        int idx, lives;
    } row_t;
    row_t tbl[13];

    initial begin
        logic [9:0] act, want;
        int first;

        //            frames st    col   go    rn    dm    dmc   ce    ex    idx lives
        tbl[0]  = '{0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3};
        tbl[2]  = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 3};
        tbl[3]  = '{8,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3};
        tbl[4]  = '{8,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 3};
        tbl[5]  = '{103, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 3};
        tbl[6]  = '{1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 3};
        tbl[7]  = '{0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 2};
        tbl[8]  = '{4,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2};
        tbl[9]  = '{27,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7, 2};
        tbl[10] = '{1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2};
        tbl[11] = '{59,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2};
        tbl[12] = '{1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2};

        model_reset();
        do_reset();

        for (int r = 0; r < 13; r++) begin
            if (tbl[r].frames == 0) cycle(1'b0, tbl[r].st, tbl[r].col);
            else                    apply_frames(tbl[r].frames, tbl[r].st, tbl[r].col);
            act  = {bus.game_over, bus.ship_resetN, bus.draw_mask, bus.collision_en,
                    bus.exploding, bus.explode_idx, bus.lives};
            want = {tbl[r].go, tbl[r].rn, tbl[r].dm, tbl[r].ce, tbl[r].ex,
                    IDX_W'(tbl[r].idx), LIVES_W'(tbl[r].lives)};
            if (!tbl[r].dmc) begin act[7] = 1'b0; want[7] = 1'b0; end
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL table row=%0d got=%03h want=%03h", r, act, want);
            end
        end

        // Collision coincident with a frame pulse in ALIVE.
        apply_frames(INVULN_FRAMES, 1'b0, 1'b0);
        expect_val("alive_reached", int'(bus.collision_en), 1);
        cycle(1'b1, 1'b0, 1'b1);
        expect_val("coinc_exploding", int'(bus.exploding), 1);
        expect_val("coinc_idx", int'(bus.explode_idx), 0);
        expect_val("coinc_lives", int'(bus.lives), 1);
        apply_frames(EXPLODE_FRAMES - 1, 1'b0, 1'b0);
        expect_val("explode_31_still", int'(bus.exploding), 1);
        expect_val("explode_31_idx", int'(bus.explode_idx), 7);
        apply_frames(1, 1'b0, 1'b0);
        expect_val("explode_32_done", int'(bus.exploding), 0);
        apply_frames(RESPAWN_FRAMES, 1'b0, 1'b0);
        expect_val("respawn_resetN", int'(bus.ship_resetN), 1);

        // Last life lost, start ignored in flight, fresh start reloads.
        apply_frames(INVULN_FRAMES, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        expect_val("start_ignored_go", int'(bus.game_over), 0);
        expect_val("start_ignored_lives", int'(bus.lives), 1);
        cycle(1'b0, 1'b0, 1'b1);
        expect_val("last_life_lives", int'(bus.lives), 0);
        apply_frames(EXPLODE_FRAMES, 1'b0, 1'b1);
        apply_frames(RESPAWN_FRAMES, 1'b0, 1'b0);
        expect_val("gameover_go", int'(bus.game_over), 1);
        expect_val("gameover_lives", int'(bus.lives), 0);
        expect_val("gameover_resetN", int'(bus.ship_resetN), 0);
        cycle(1'b0, 1'b1, 1'b0);
        expect_val("restart_lives", int'(bus.lives), 3);
        expect_val("restart_go", int'(bus.game_over), 0);
        cycle(1'b0, 1'b0, 1'b0);
        expect_val("restart_resetN", int'(bus.ship_resetN), 1);

        // Reset in the middle of an explosion, then anim divider restart.
        apply_frames(INVULN_FRAMES, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        apply_frames(5, 1'b0, 1'b0);
        expect_val("pre_reset_idx", int'(bus.explode_idx), 1);
        do_reset();
        expect_val("midreset_go", int'(bus.game_over), 1);
        expect_val("midreset_ex", int'(bus.exploding), 0);
        expect_val("midreset_lives", int'(bus.lives), 0);
        first = -1;
        for (int f = 1; f <= 8; f++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (bus.anim_pulse && first < 0) first = f;
            cycle(1'b0, 1'b0, 1'b0);
        end
        expect_val("anim_first_frame", first, 6);

        // Random stimulus against the model.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 9) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
